psum_acc_core: RTL and testbench

PSUM_ACC_CORE -- requirements
Module: psum_acc_core

---
 rtl/psum_acc_core_pkg.sv | 15 +
 rtl/psum_acc_core_sat_add.sv | 25 ++
 rtl/psum_acc_core.sv | 155 +++++++++++++++
 tb/tb_psum_acc_core.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_acc_core_pkg.sv
// Shared definitions for the partial-sum accumulator: FSM states and default sizing.
package psum_acc_core_pkg;

    localparam int DEF_COL     = 8;
    localparam int DEF_PSUM_BW = 16;
    localparam int DEF_DEPTH   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/psum_acc_core_sat_add.sv
// One column of the accumulator: signed add that clamps to the representable range.
module sat_add #(
    parameter int psum_bw = 16
) (
    input  logic [psum_bw-1:0] a_i,
    input  logic [psum_bw-1:0] b_i,
    output logic [psum_bw-1:0] sum_o,
    output logic               ovf_o
);

    logic [psum_bw:0] sum_full;

    // One guard bit: overflow shows up as a disagreement between the guard and the sign bit.
    assign sum_full = {a_i[psum_bw-1], a_i} + {b_i[psum_bw-1], b_i};
    assign ovf_o    = sum_full[psum_bw] ^ sum_full[psum_bw-1];

    always_comb begin
        sum_o = sum_full[psum_bw-1:0];
        if (ovf_o) begin
            sum_o = sum_full[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                                      : {1'b0, {(psum_bw-1){1'b1}}};
        end
    end

endmodule

// File: rtl/psum_acc_core.sv
// Multi-pass partial-sum accumulator: sums OFIFO vectors into a flop array, then drains them.
module psum_acc_core
    import psum_acc_core_pkg::*;
#(
    parameter int col     = DEF_COL,
    parameter int psum_bw = DEF_PSUM_BW,
    parameter int depth   = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [$clog2(depth):0]   cfg_len,
    input  logic [3:0]               cfg_passes,
    input  logic                     cfg_relu,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [col*psum_bw-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [col*psum_bw-1:0]   out_data,
    output logic                     busy,
    output logic                     done,
    output logic                     sat_flag
);

    localparam int aw = $clog2(depth) + 1;
    localparam int iw = (depth > 1) ? $clog2(depth) : 1;
    localparam int vw = col * psum_bw;

    state_e          state_q, state_d;
    logic [aw-1:0]   len_q, len_d, ptr_q, ptr_d, rd_ptr_q, rd_ptr_d;
    logic [3:0]      passes_q, passes_d, pass_q, pass_d;
    logic            relu_q, relu_d, sat_q, sat_d;
    logic [vw-1:0]   mem_q [depth];
    logic [vw-1:0]   acc_sum, wr_data, rd_vec;
    logic [col-1:0]  col_ovf;
    logic [aw-1:0]   len_clamped;
    logic            xfer, last_vec, last_pass, rd_hs, rd_last;

    assign len_clamped = (cfg_len > aw'(depth)) ? aw'(depth) : cfg_len;
    assign xfer        = in_valid && (state_q == ACCUM);
    assign rd_hs       = out_ready && (state_q == DRAIN);
    assign last_vec    = (ptr_q == len_q - aw'(1));
    assign last_pass   = (pass_q == passes_q - 4'd1);
    assign rd_last     = (rd_ptr_q == len_q - aw'(1));
    assign rd_vec      = mem_q[rd_ptr_q[iw-1:0]];

    for (genvar c = 0; c < col; c++) begin : g_col
        sat_add #(.psum_bw(psum_bw)) u_sat_add (
            .a_i   (mem_q[ptr_q[iw-1:0]][c*psum_bw +: psum_bw]),
            .b_i   (in_data[c*psum_bw +: psum_bw]),
            .sum_o (acc_sum[c*psum_bw +: psum_bw]),
            .ovf_o (col_ovf[c])
        );
    end

    // Pass 0 overwrites, so stale contents from a previous job or reset never leak in.
    assign wr_data = (pass_q == 4'd0) ? in_data : acc_sum;

    always_ff @(posedge clk) begin
        if (xfer) begin
            mem_q[ptr_q[iw-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            len_q    <= '0;
            passes_q <= '0;
            relu_q   <= 1'b0;
            ptr_q    <= '0;
            pass_q   <= '0;
            rd_ptr_q <= '0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            passes_q <= passes_d;
            relu_q   <= relu_d;
            ptr_q    <= ptr_d;
            pass_q   <= pass_d;
            rd_ptr_q <= rd_ptr_d;
            sat_q    <= sat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (cfg_len == '0 || cfg_passes == 4'd0) ? DONE : ACCUM;
            ACCUM:   if (xfer && last_vec && last_pass) state_d = DRAIN;
            DRAIN:   if (rd_hs && rd_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        len_d    = len_q;
        passes_d = passes_q;
        relu_d   = relu_q;
        ptr_d    = ptr_q;
        pass_d   = pass_q;
        rd_ptr_d = rd_ptr_q;
        sat_d    = sat_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d    = len_clamped;
                    passes_d = cfg_passes;
                    relu_d   = cfg_relu;
                    ptr_d    = '0;
                    pass_d   = '0;
                    rd_ptr_d = '0;
                    sat_d    = 1'b0;
                end
            end
            ACCUM: begin
                if (xfer) begin
                    if (pass_q != 4'd0) sat_d = sat_q | (|col_ovf);
                    if (last_vec) begin
                        ptr_d  = '0;
                        pass_d = pass_q + 4'd1;
                        if (last_pass) rd_ptr_d = '0;
                    end else begin
                        ptr_d = ptr_q + aw'(1);
                    end
                end
            end
            DRAIN: begin
                if (rd_hs) rd_ptr_d = rd_ptr_q + aw'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == DRAIN);
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        sat_flag  = sat_q;
        out_data  = '0;
        if (state_q == DRAIN) begin
            out_data = rd_vec;
            if (relu_q) begin
                for (int c = 0; c < col; c++) begin
                    if (rd_vec[c*psum_bw + psum_bw - 1]) out_data[c*psum_bw +: psum_bw] = '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_psum_acc_core.sv
// Scoreboard bench for psum_acc_core: directed jobs push expected drain vectors, a monitor checks them.
module tb_psum_acc_core;

    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 5;
    localparam int VW    = COL * BW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] cfgLen = '0;
    logic [3:0]    cfgPasses = '0;
    logic          cfgRelu = 1'b0;
    logic          inValid = 1'b0;
    logic [VW-1:0] inData = '0;
    logic          outReady = 1'b1;
    logic          inReady, outValid, busy, done, satFlag;
    logic [VW-1:0] outData;

    int            testsRun = 0;
    int            testsFailed = 0;
    int            doneCount = 0;
    int            popCount = 0;
    int            stallChecks = 0;
    int            jobDoneBase = 0;
    bit            outValidSeen = 1'b0;
    bit            stalled = 1'b0;
    bit            prevDone = 1'b0;
    logic [VW-1:0] heldData = '0;
    logic [VW-1:0] sbQueue[$];

    psum_acc_core #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cfg_len    (cfgLen),
        .cfg_passes (cfgPasses),
        .cfg_relu   (cfgRelu),
        .in_valid   (inValid),
        .in_ready   (inReady),
        .in_data    (inData),
        .out_valid  (outValid),
        .out_ready  (outReady),
        .out_data   (outData),
        .busy       (busy),
        .done       (done),
        .sat_flag   (satFlag)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [VW-1:0] actual, input logic [VW-1:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [VW-1:0] splat(input int v);
        logic [VW-1:0] r;
        for (int c = 0; c < COL; c++) r[c*BW +: BW] = BW'(v);
        return r;
    endfunction

    function automatic logic [VW-1:0] vec8(input int c0, input int c1, input int c2, input int c3,
                                           input int c4, input int c5, input int c6, input int c7);
        int a[8];
        logic [VW-1:0] r;
        a = '{c0, c1, c2, c3, c4, c5, c6, c7};
        for (int c = 0; c < COL; c++) r[c*BW +: BW] = BW'(a[c]);
        return r;
    endfunction

    // Monitor: pops the scoreboard on each drain handshake, checks stall stability and done width.
    always @(negedge clk) begin
        if (outValid) outValidSeen = 1'b1;
        if (!outValid) checkOutput("idle_out_data_zero", outData, '0);
        if (stalled && outValid) begin
            stallChecks++;
            checkOutput("stall_hold", outData, heldData);
        end
        stalled  = outValid && !outReady;
        heldData = outData;
        if (outValid && outReady) begin
            if (sbQueue.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL drain_unexpected: got %h, expected no vector", outData);
            end else begin
                checkOutput("drain_data", outData, sbQueue.pop_front());
            end
            popCount++;
        end
        if (done) begin
            checkOutput("done_single_cycle", VW'(prevDone), VW'(0));
            doneCount++;
        end
        prevDone = done;
    end

    task automatic applyStimulus(input logic [AW-1:0] len, input logic [3:0] passes, input logic relu);
        jobDoneBase  = doneCount;
        outValidSeen = 1'b0;
        cfgLen       = len;
        cfgPasses    = passes;
        cfgRelu      = relu;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        cfgLen    = 5'd1;
        cfgPasses = 4'hF;
        cfgRelu   = ~relu;
    endtask

    task automatic sendVec(input logic [VW-1:0] v, input bit randGaps);
        bit accepted;
        int guard = 0;
        if (randGaps) begin
            for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
                inValid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        inValid = 1'b1;
        inData  = v;
        forever begin
            @(negedge clk);
            accepted = inReady;
            @(posedge clk);
            #1;
            if (accepted) break;
            guard++;
            if (guard > 50) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL send_timeout: got in_ready=0, expected 1 within 50 cycles");
                break;
            end
        end
        inValid = 1'b0;
        inData  = splat(16'h5A5A);
    endtask

    task automatic waitJobEnd(input string name);
        int cycles = 0;
        while (doneCount == jobDoneBase && cycles < 400) begin
            @(posedge clk);
            cycles++;
        end
        if (doneCount == jobDoneBase) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s_timeout: got no done after %0d cycles, expected done", name, cycles);
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput({name, "_done_count"}, VW'(doneCount - jobDoneBase), VW'(1));
        checkOutput({name, "_queue_empty"}, VW'(sbQueue.size()), VW'(0));
        checkOutput({name, "_busy_idle"}, VW'(busy), VW'(0));
    endtask

    initial begin
        int base;
        int guard;

        @(negedge clk);
        checkOutput("rst_busy", VW'(busy), VW'(0));
        checkOutput("rst_in_ready", VW'(inReady), VW'(0));
        checkOutput("rst_out_valid", VW'(outValid), VW'(0));
        checkOutput("rst_done", VW'(done), VW'(0));
        checkOutput("rst_sat_flag", VW'(satFlag), VW'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Single pass, with a stray start mid-job that must be ignored.
        applyStimulus(5'd4, 4'd1, 1'b0);
        for (int k = 1; k <= 4; k++) sbQueue.push_back(splat(k));
        for (int k = 1; k <= 4; k++) begin
            sendVec(splat(k), 1'b0);
            if (k == 2) begin
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        waitJobEnd("single");
        checkOutput("single_sat_flag", VW'(satFlag), VW'(0));

        applyStimulus(5'd2, 4'd3, 1'b1);
        sbQueue.push_back(splat(0));
        sbQueue.push_back(splat(0));
        for (int k = 0; k < 6; k++) sendVec(splat(-5), 1'b0);
        waitJobEnd("relu_on");

        applyStimulus(5'd2, 4'd3, 1'b0);
        sbQueue.push_back(splat(-15));
        sbQueue.push_back(splat(-15));
        for (int k = 0; k < 6; k++) sendVec(splat(-5), 1'b0);
        waitJobEnd("relu_off");
        checkOutput("relu_off_sat_flag", VW'(satFlag), VW'(0));

        applyStimulus(5'd1, 4'd2, 1'b1);
        sbQueue.push_back(vec8(0, 0, 0, 0, 1, 2, 3, 4));
        sendVec(vec8(-4, -3, -2, -1, 0, 1, 2, 3), 1'b0);
        sendVec(splat(1), 1'b0);
        waitJobEnd("mixed_cols");

        applyStimulus(5'd1, 4'd2, 1'b0);
        sbQueue.push_back(vec8(32767, -32768, -100, 0, 0, 0, 0, 0));
        sendVec(vec8(30000, -30000, 100, 0, 0, 0, 0, 0), 1'b0);
        sendVec(vec8(30000, -30000, -200, 0, 0, 0, 0, 0), 1'b0);
        waitJobEnd("saturate");
        checkOutput("sat_flag_set", VW'(satFlag), VW'(1));
        applyStimulus(5'd1, 4'd1, 1'b0);
        checkOutput("sat_flag_cleared", VW'(satFlag), VW'(0));
        sbQueue.push_back(splat(9));
        sendVec(splat(9), 1'b0);
        waitJobEnd("after_sat");

        // Random input gaps plus a 5-cycle consumer stall after the second drained vector.
        applyStimulus(5'd6, 4'd2, 1'b0);
        base = popCount;
        for (int k = 1; k <= 6; k++) sbQueue.push_back(splat(11 * k));
        for (int k = 1; k <= 6; k++) sendVec(splat(k), 1'b1);
        for (int k = 1; k <= 6; k++) sendVec(splat(10 * k), 1'b1);
        guard = 0;
        while (popCount < base + 2 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        checkOutput("bp_drain_started", VW'(popCount >= base + 2), VW'(1));
        #1;
        outReady = 1'b0;
        base = stallChecks;
        repeat (5) @(posedge clk);
        #1;
        outReady = 1'b1;
        checkOutput("bp_stall_observed", VW'(stallChecks - base >= 4), VW'(1));
        waitJobEnd("backpressure");

        applyStimulus(5'd8, 4'd1, 1'b0);
        for (int k = 1; k <= 3; k++) sendVec(splat(k), 1'b0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midrst_busy", VW'(busy), VW'(0));
        checkOutput("midrst_in_ready", VW'(inReady), VW'(0));
        checkOutput("midrst_out_valid", VW'(outValid), VW'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;
        applyStimulus(5'd1, 4'd1, 1'b0);
        sbQueue.push_back(splat(7));
        sendVec(splat(7), 1'b0);
        waitJobEnd("after_reset");

        applyStimulus(5'd0, 4'd2, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("len0_done_pulses", VW'(doneCount - jobDoneBase), VW'(1));
        checkOutput("len0_no_out_valid", VW'(outValidSeen), VW'(0));
        checkOutput("len0_busy_idle", VW'(busy), VW'(0));

        applyStimulus(5'd3, 4'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("pass0_done_pulses", VW'(doneCount - jobDoneBase), VW'(1));
        checkOutput("pass0_no_out_valid", VW'(outValidSeen), VW'(0));

        applyStimulus(5'(DEPTH + 5), 4'd1, 1'b0);
        for (int k = 0; k < DEPTH; k++) sbQueue.push_back(splat(100 + k));
        for (int k = 0; k < DEPTH; k++) sendVec(splat(100 + k), 1'b0);
        waitJobEnd("clamp_len");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
